systolic_input_skew: RTL and testbench

Upstream feeder for the `LENGTH x LENGTH` systolic matrix-multiply array. It accepts one unskewed input vector per cycle over a valid/ready handshake. It delays lane `i` by `i` extra cycles so the array's west edge sees the diagonal wavefront it expects. It also drives the array's enable. After the last vector it flushes zeros until every lane has emptied, then pulses `done`.

---
 rtl/mmu_pkg.sv | 18 +
 rtl/skew_delay_line.sv | 34 +++
 rtl/systolic_input_skew.sv | 104 ++++++++++
 tb/tb_systolic_input_skew.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and helpers for the systolic matrix-multiply feeder blocks.
//   skew_state_e : feeder FSM states
//   cnt_w()      : width of the drain counter for a given lane count
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } skew_state_e;

  // A one-lane array still needs a 1-bit counter, so the width never drops to 0.
  function automatic int unsigned cnt_w(input int unsigned length);
    return (length > 1) ? $clog2(length) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Enable-gated shift register used as one lane of the input skew.
//   clk, rst_n : clock, asynchronous active-low clear
//   sync_clr   : synchronous active-high clear
//   en         : shift strobe; contents hold when low
//   din        : stage-0 input
//   dout       : last stage (DEPTH cycles of en after din)
module skew_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (sync_clr) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int unsigned k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_input_skew.sv
// Upstream feeder for a LENGTH x LENGTH systolic array. Accepts one unskewed
// vector per cycle, delays lane i by i extra advances, then flushes LENGTH-1
// zero advances after the last vector and pulses done.
//   CLK, ASYNC_RST (active-low async), SYNC_RST (active-high sync clear)
//   in_valid/in_ready/in_last/in_vector : producer handshake, lane i at
//                                         in_vector[i*WIDTH +: WIDTH]
//   skew_out : skewed lanes to the array's Inputs
//   array_en : advance strobe to the array's EN
//   busy     : not IDLE
//   done     : one-cycle pulse after the flush
module systolic_input_skew
  import mmu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 256
) (
  input  logic                    CLK,
  input  logic                    ASYNC_RST,
  input  logic                    SYNC_RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [WIDTH*LENGTH-1:0] in_vector,
  output logic [WIDTH*LENGTH-1:0] skew_out,
  output logic                    array_en,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CW         = cnt_w(LENGTH);
  localparam int unsigned DRAIN_LOAD = (LENGTH >= 2) ? LENGTH - 2 : 0;

  skew_state_e   state, state_nxt;
  logic [CW-1:0] drain_cnt, drain_cnt_nxt;
  logic          ready_ok;
  logic          accept;
  logic          advance;

  // Ready is masked by both resets so a clear always wins over acceptance
  // and nothing is taken while the async reset is held.
  assign ready_ok = ((state == IDLE) || (state == STREAM)) & ASYNC_RST & ~SYNC_RST;
  assign in_ready = ready_ok;
  assign accept   = in_valid & ready_ok;
  assign advance  = ~SYNC_RST & (accept | (state == DRAIN));
  assign array_en = advance;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else if (SYNC_RST) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_nxt     = (LENGTH == 1) ? DONE : DRAIN;
            drain_cnt_nxt = CW'(DRAIN_LOAD);
          end else begin
            state_nxt = STREAM;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = DONE;
        else                 drain_cnt_nxt = drain_cnt - CW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    logic [WIDTH-1:0] lane_din;

    // Only accept or DRAIN can advance, so anything but accept feeds zeros.
    assign lane_din = accept ? in_vector[i*WIDTH +: WIDTH] : '0;

    skew_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(i + 1)
    ) u_line (
      .clk     (CLK),
      .rst_n   (ASYNC_RST),
      .sync_clr(SYNC_RST),
      .en      (advance),
      .din     (lane_din),
      .dout    (skew_out[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_input_skew.sv
module tb_systolic_input_skew;

  localparam int unsigned W = 8;
  localparam int unsigned L = 4;

  logic          CLK = 1'b0;
  logic          ASYNC_RST;
  logic          SYNC_RST;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [W*L-1:0] in_vector;
  logic [W*L-1:0] skew_out;
  logic          array_en;
  logic          busy;
  logic          done;

  systolic_input_skew #(.WIDTH(W), .LENGTH(L)) dut (
    .CLK      (CLK),
    .ASYNC_RST(ASYNC_RST),
    .SYNC_RST (SYNC_RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .in_vector(in_vector),
    .skew_out (skew_out),
    .array_en (array_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: history of vectors fed into stage 0 on each advance.
  // Lane i shows the vector pushed i advances before the most recent one.
  logic [31:0] hist[$];
  int          owed;       // zero advances still to be emitted
  bit          done_next;  // done expected this cycle
  bit          mid;        // inside a matrix (accepted non-last)

  logic [31:0] snap_skew;
  bit          snap_ready, snap_en, snap_done, snap_busy;

  function automatic logic [31:0] exp_skew();
    logic [31:0] r;
    int n;
    r = '0;
    n = hist.size();
    for (int i = 0; i < int'(L); i++)
      if (n > i) r[i*8 +: 8] = hist[n-1-i][i*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    owed      = 0;
    done_next = 0;
    mid       = 0;
  endtask

  task automatic cycle(input bit v, input bit last, input logic [31:0] vec,
                       input bit srst, input string tag);
    bit m_ready, m_acc, m_adv;
    @(negedge CLK);
    in_valid  = v;
    in_last   = last;
    in_vector = vec;
    SYNC_RST  = srst;
    #1;
    m_ready = (owed == 0) && !done_next && !srst;
    m_acc   = v && m_ready;
    m_adv   = !srst && (m_acc || owed > 0);
    check({tag, ".skew"},  skew_out,        exp_skew());
    check({tag, ".ready"}, 32'(in_ready),   32'(m_ready));
    check({tag, ".en"},    32'(array_en),   32'(m_adv));
    check({tag, ".done"},  32'(done),       32'(done_next));
    check({tag, ".busy"},  32'(busy),       32'(mid || owed > 0 || done_next));
    snap_skew  = skew_out;
    snap_ready = in_ready;
    snap_en    = array_en;
    snap_done  = done;
    snap_busy  = busy;
    @(posedge CLK);
    if (srst) begin
      model_clear();
    end else begin
      done_next = 0;
      if (m_adv) begin
        hist.push_back(m_acc ? vec : 32'h0);
        if (hist.size() > int'(L)) void'(hist.pop_front());
      end
      if (owed > 0) begin
        owed--;
        if (owed == 0) done_next = 1;
      end else if (m_acc) begin
        if (last) begin
          mid  = 0;
          owed = int'(L) - 1;
          if (owed == 0) done_next = 1;
        end else begin
          mid = 1;
        end
      end
    end
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, $urandom, 0, tag);
  endtask

  task automatic areset(input int n);
    @(negedge CLK);
    ASYNC_RST = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_valid  = 1'($urandom);
      in_last   = 1'($urandom);
      in_vector = $urandom;
      SYNC_RST  = 1'($urandom);
      #1;
      check("arst.skew",  skew_out,      32'h0);
      check("arst.ready", 32'(in_ready), 32'h0);
      check("arst.en",    32'(array_en), 32'h0);
      check("arst.busy",  32'(busy),     32'h0);
      check("arst.done",  32'(done),     32'h0);
      @(negedge CLK);
    end
    model_clear();
    ASYNC_RST = 1'b1;
    SYNC_RST  = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    #1;
    check("arst.release_ready", 32'(in_ready), 32'h1);
  endtask

  initial begin
    ASYNC_RST = 1'b0;
    SYNC_RST  = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_vector = '0;
    model_clear();
    areset(3);

    // Single last vector {1,2,3,4}
    cycle(1, 1, 32'h04030201, 0, "single_acc");
    idle("single_c1"); check("single_c1_lit", snap_skew, 32'h00000001);
    idle("single_c2"); check("single_c2_lit", snap_skew, 32'h00000200);
    idle("single_c3"); check("single_c3_lit", snap_skew, 32'h00030000);
    idle("single_c4"); check("single_c4_lit", snap_skew, 32'h04000000);
    check("single_done_lit", 32'(snap_done), 32'h1);
    idle("single_c5"); check("single_idle_lit", 32'(snap_busy), 32'h0);

    // Back-to-back
    cycle(1, 0, 32'h01010101, 0, "b2b_v1");
    cycle(1, 0, 32'h02020202, 0, "b2b_v2");
    cycle(1, 1, 32'h03030303, 0, "b2b_v3");
    idle("b2b_c3"); check("b2b_c3_lit", snap_skew, 32'h00010203);
    idle("b2b_c4"); check("b2b_c4_lit", snap_skew, 32'h01020300);
    idle("b2b_c5");
    idle("b2b_c6"); check("b2b_done_lit", 32'(snap_done), 32'h1);
    idle("b2b_c7");

    // Stall
    cycle(1, 0, 32'h08070605, 0, "stall_acc");
    idle("stall_s1"); check("stall_s1_lit", snap_skew, 32'h00000005);
    check("stall_s1_en", 32'(snap_en), 32'h0);
    idle("stall_s2"); check("stall_s2_lit", snap_skew, 32'h00000005);
    cycle(1, 1, 32'h04030201, 0, "stall_resume");
    idle("stall_r1"); check("stall_r1_lit", snap_skew, 32'h00000601);
    for (int k = 0; k < 4; k++) idle("stall_drain");

    // Backpressure: valid held through DRAIN and DONE
    cycle(1, 1, 32'h04030201, 0, "bp_acc");
    for (int k = 0; k < 4; k++) cycle(1, 0, 32'h09090909, 0, "bp_hold");
    check("bp_done_ready_lit", 32'(snap_ready), 32'h0);
    cycle(1, 1, 32'h09090909, 0, "bp_take");
    check("bp_take_ready_lit", 32'(snap_ready), 32'h1);
    idle("bp_after"); check("bp_after_lit", snap_skew, 32'h00000009);
    for (int k = 0; k < 4; k++) idle("bp_drain");

    // Mid-drain synchronous reset
    cycle(1, 1, 32'h04030201, 0, "md_acc");
    idle("md_d1");
    cycle(0, 0, 32'h0, 1, "md_srst");
    idle("md_after");
    check("md_after_skew_lit", snap_skew, 32'h0);
    check("md_after_busy_lit", 32'(snap_busy), 32'h0);
    for (int k = 0; k < 4; k++) idle("md_quiet");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (n == 200) areset(2);
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 49) == 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
